rs_station: RTL and testbench

Parametrised reservation station for the Tomasulo core. It holds up to `ENTRIES` in-flight instructions of one functional-unit class, each tagged with its ROB index. Each entry captures source operands either at allocation or by snooping the common data bus (CDB). Once both operands are present, the station issues the entry to its functional unit through a valid/ready handshake. One instance sits in front of each unit class (add/branch/load-store, mul/div), between the issue stage and the execution units.

---
 rtl/rs_station.sv | 211 +++++++++++++++++++++
 tb/tb_rs_station.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_station.sv
// Reservation station for one functional-unit class of the Tomasulo core.
// Holds up to ENTRIES instructions, captures operands at allocation or from
// the CDB, and issues the lowest-index ready entry over a valid/ready
// handshake. A stalled selection is held until the unit accepts it.
//
// Build option: RS_CDB_BYPASS_EN
//   defined   - a CDB broadcast that matches a not-ready source tag of the
//               allocating instruction is captured into the new entry.
//   undefined - such an allocation is refused for that cycle so the producer
//               retries after the broadcast has been seen.
module rs_station #(
  parameter int ENTRIES = 4,
  parameter int DATA_W  = 16,
  parameter int TAG_W   = 3,
  parameter int FUNC_W  = 4
) (
  input  logic                             clk1,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic                             alloc_valid,
  output logic                             alloc_ready,
  input  logic [FUNC_W-1:0]                alloc_func,
  input  logic [TAG_W-1:0]                 alloc_rob,
  input  logic                             alloc_src1_rdy,
  input  logic                             alloc_src2_rdy,
  input  logic [DATA_W-1:0]                alloc_src1,
  input  logic [DATA_W-1:0]                alloc_src2,
  input  logic                             cdb_valid,
  input  logic [TAG_W-1:0]                 cdb_tag,
  input  logic [DATA_W-1:0]                cdb_data,
  output logic                             iss_valid,
  input  logic                             iss_ready,
  output logic [FUNC_W-1:0]                iss_func,
  output logic [TAG_W-1:0]                 iss_rob,
  output logic [DATA_W-1:0]                iss_op1,
  output logic [DATA_W-1:0]                iss_op2,
  output logic [$clog2(ENTRIES+1)-1:0]     count
);

  localparam int CNT_W = $clog2(ENTRIES + 1);
  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] busy_q, busy_d;
  logic [ENTRIES-1:0] s1_rdy_q, s1_rdy_d;
  logic [ENTRIES-1:0] s2_rdy_q, s2_rdy_d;
  logic [FUNC_W-1:0]  func_q [ENTRIES];
  logic [FUNC_W-1:0]  func_d [ENTRIES];
  logic [TAG_W-1:0]   rob_q  [ENTRIES];
  logic [TAG_W-1:0]   rob_d  [ENTRIES];
  logic [DATA_W-1:0]  s1_q   [ENTRIES];
  logic [DATA_W-1:0]  s1_d   [ENTRIES];
  logic [DATA_W-1:0]  s2_q   [ENTRIES];
  logic [DATA_W-1:0]  s2_d   [ENTRIES];
  logic [CNT_W-1:0]   count_q, count_d;
  logic               lock_q, lock_d;
  logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;

  logic [ENTRIES-1:0] ready_vec;
  logic [IDX_W-1:0]   rdy_idx;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   sel_idx;
  logic               s1_hit, s2_hit;
  logic               alloc_block;
  logic               alloc_fire, iss_fire;

  assign ready_vec = busy_q & s1_rdy_q & s2_rdy_q;

  // Lowest-index entry with both operands present (last write wins).
  always_comb begin
    rdy_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (ready_vec[i]) rdy_idx = IDX_W'(i);
    end
  end

  // Lowest-index free entry; only meaningful while count is below ENTRIES.
  always_comb begin
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IDX_W'(i);
    end
  end

  // A held selection overrides the priority pick so outputs stay stable.
  assign sel_idx   = lock_q ? lock_idx_q : rdy_idx;
  assign iss_valid = lock_q | (|ready_vec);

  // Issue outputs are forced to zero when nothing is selectable.
  always_comb begin
    iss_func = '0;
    iss_rob  = '0;
    iss_op1  = '0;
    iss_op2  = '0;
    if (iss_valid) begin
      iss_func = func_q[sel_idx];
      iss_rob  = rob_q[sel_idx];
      iss_op1  = s1_q[sel_idx];
      iss_op2  = s2_q[sel_idx];
    end
  end

  // Detect a CDB broadcast that matches a pending tag of the allocating op.
  always_comb begin
    s1_hit = cdb_valid && !alloc_src1_rdy && (alloc_src1[TAG_W-1:0] == cdb_tag);
    s2_hit = cdb_valid && !alloc_src2_rdy && (alloc_src2[TAG_W-1:0] == cdb_tag);
`ifdef RS_CDB_BYPASS_EN
    alloc_block = 1'b0;
`else
    alloc_block = s1_hit | s2_hit;
`endif
  end

  assign alloc_ready = (count_q != CNT_W'(ENTRIES)) && !flush && !alloc_block;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign iss_fire    = iss_valid && iss_ready;
  assign count       = count_q;

  // Next state: flush dominates; otherwise wakeup, issue, allocate.
  always_comb begin
    busy_d     = busy_q;
    s1_rdy_d   = s1_rdy_q;
    s2_rdy_d   = s2_rdy_q;
    func_d     = func_q;
    rob_d      = rob_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    count_d    = count_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;

    if (flush) begin
      busy_d  = '0;
      lock_d  = 1'b0;
      count_d = '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (busy_q[i] && cdb_valid) begin
          if (!s1_rdy_q[i] && (s1_q[i][TAG_W-1:0] == cdb_tag)) begin
            s1_rdy_d[i] = 1'b1;
            s1_d[i]     = cdb_data;
          end
          if (!s2_rdy_q[i] && (s2_q[i][TAG_W-1:0] == cdb_tag)) begin
            s2_rdy_d[i] = 1'b1;
            s2_d[i]     = cdb_data;
          end
        end
      end

      if (iss_fire) begin
        busy_d[sel_idx] = 1'b0;
        lock_d          = 1'b0;
      end else if (iss_valid) begin
        lock_d     = 1'b1;
        lock_idx_d = sel_idx;
      end

      if (alloc_fire) begin
        busy_d[free_idx] = 1'b1;
        func_d[free_idx] = alloc_func;
        rob_d[free_idx]  = alloc_rob;
`ifdef RS_CDB_BYPASS_EN
        s1_rdy_d[free_idx] = alloc_src1_rdy | s1_hit;
        s2_rdy_d[free_idx] = alloc_src2_rdy | s2_hit;
        s1_d[free_idx]     = s1_hit ? cdb_data : alloc_src1;
        s2_d[free_idx]     = s2_hit ? cdb_data : alloc_src2;
`else
        s1_rdy_d[free_idx] = alloc_src1_rdy;
        s2_rdy_d[free_idx] = alloc_src2_rdy;
        s1_d[free_idx]     = alloc_src1;
        s2_d[free_idx]     = alloc_src2;
`endif
      end

      case ({alloc_fire, iss_fire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      s1_rdy_q   <= '0;
      s2_rdy_q   <= '0;
      count_q    <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        func_q[i] <= '0;
        rob_q[i]  <= '0;
        s1_q[i]   <= '0;
        s2_q[i]   <= '0;
      end
    end else begin
      busy_q     <= busy_d;
      s1_rdy_q   <= s1_rdy_d;
      s2_rdy_q   <= s2_rdy_d;
      count_q    <= count_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      func_q     <= func_d;
      rob_q      <= rob_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

endmodule

// File: tb/tb_rs_station.sv
// Bench for rs_station: a behavioural model of the station's entry table is
// checked against the DUT on every falling edge, plus directed literal checks.
module tb_rs_station;

  localparam int E  = 4;
  localparam int DW = 16;
  localparam int TW = 3;
  localparam int FW = 4;

  logic          clk1 = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          alloc_valid = 1'b0;
  logic          alloc_ready;
  logic [FW-1:0] alloc_func = '0;
  logic [TW-1:0] alloc_rob = '0;
  logic          alloc_src1_rdy = 1'b0;
  logic          alloc_src2_rdy = 1'b0;
  logic [DW-1:0] alloc_src1 = '0;
  logic [DW-1:0] alloc_src2 = '0;
  logic          cdb_valid = 1'b0;
  logic [TW-1:0] cdb_tag = '0;
  logic [DW-1:0] cdb_data = '0;
  logic          iss_valid;
  logic          iss_ready = 1'b0;
  logic [FW-1:0] iss_func;
  logic [TW-1:0] iss_rob;
  logic [DW-1:0] iss_op1;
  logic [DW-1:0] iss_op2;
  logic [2:0]    count;

  int total = 0;
  int bad   = 0;

  rs_station #(.ENTRIES(E), .DATA_W(DW), .TAG_W(TW), .FUNC_W(FW)) dut (
    .clk1(clk1), .rst_n(rst_n), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_func(alloc_func), .alloc_rob(alloc_rob),
    .alloc_src1_rdy(alloc_src1_rdy), .alloc_src2_rdy(alloc_src2_rdy),
    .alloc_src1(alloc_src1), .alloc_src2(alloc_src2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_func(iss_func), .iss_rob(iss_rob),
    .iss_op1(iss_op1), .iss_op2(iss_op2),
    .count(count)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_busy [E];
  bit          m_r1   [E];
  bit          m_r2   [E];
  int unsigned m_v1   [E];
  int unsigned m_v2   [E];
  int unsigned m_func [E];
  int unsigned m_rob  [E];
  int          m_held = -1;

  function automatic int m_sel();
    if (m_held >= 0) return m_held;
    for (int i = 0; i < E; i++)
      if (m_busy[i] && m_r1[i] && m_r2[i]) return i;
    return -1;
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < E; i++) if (m_busy[i]) n++;
    return n;
  endfunction

  function automatic bit hit1();
    logic [DW-1:0] v = alloc_src1;
    return cdb_valid && !alloc_src1_rdy && (v[TW-1:0] == cdb_tag);
  endfunction

  function automatic bit hit2();
    logic [DW-1:0] v = alloc_src2;
    return cdb_valid && !alloc_src2_rdy && (v[TW-1:0] == cdb_tag);
  endfunction

  function automatic bit m_alloc_ready();
    bit ok = (m_count() != E) && !flush;
`ifndef RS_CDB_BYPASS_EN
    if (hit1() || hit2()) ok = 0;
`endif
    return ok;
  endfunction

  function automatic bit tag_match(int unsigned v);
    logic [DW-1:0] w = v[DW-1:0];
    return w[TW-1:0] == cdb_tag;
  endfunction

  always @(posedge clk1 or negedge rst_n) begin
    int  s, fr;
    bit  fi, fa, h1, h2;
    if (!rst_n) begin
      for (int i = 0; i < E; i++) begin
        m_busy[i] = 0; m_r1[i] = 0; m_r2[i] = 0;
      end
      m_held = -1;
    end else begin
      s  = m_sel();
      fi = (s >= 0) && iss_ready;
      fa = alloc_valid && m_alloc_ready();
      h1 = hit1();
      h2 = hit2();
      fr = -1;
      for (int i = E - 1; i >= 0; i--) if (!m_busy[i]) fr = i;
      if (flush) begin
        for (int i = 0; i < E; i++) m_busy[i] = 0;
        m_held = -1;
      end else begin
        if (cdb_valid) begin
          for (int i = 0; i < E; i++) begin
            if (m_busy[i] && !m_r1[i] && tag_match(m_v1[i])) begin m_r1[i] = 1; m_v1[i] = cdb_data; end
            if (m_busy[i] && !m_r2[i] && tag_match(m_v2[i])) begin m_r2[i] = 1; m_v2[i] = cdb_data; end
          end
        end
        if (fi) begin
          m_busy[s] = 0;
          m_held = -1;
        end else if (s >= 0) begin
          m_held = s;
        end
        if (fa) begin
          m_busy[fr] = 1;
          m_func[fr] = alloc_func;
          m_rob[fr]  = alloc_rob;
          m_r1[fr] = alloc_src1_rdy;
          m_r2[fr] = alloc_src2_rdy;
          m_v1[fr] = alloc_src1;
          m_v2[fr] = alloc_src2;
`ifdef RS_CDB_BYPASS_EN
          if (h1) begin m_r1[fr] = 1; m_v1[fr] = cdb_data; end
          if (h2) begin m_r2[fr] = 1; m_v2[fr] = cdb_data; end
`endif
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk1) begin
    int s;
    s = m_sel();
    chk("m_count", count, m_count());
    chk("m_alloc_ready", alloc_ready, m_alloc_ready());
    chk("m_iss_valid", iss_valid, s >= 0);
    chk("m_iss_func", iss_func, (s >= 0) ? m_func[s] : 0);
    chk("m_iss_rob", iss_rob, (s >= 0) ? m_rob[s] : 0);
    chk("m_iss_op1", iss_op1, (s >= 0) ? m_v1[s] : 0);
    chk("m_iss_op2", iss_op2, (s >= 0) ? m_v2[s] : 0);
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk1);
    #1;
  endtask

  task automatic alloc(input int f, input int rob, input bit r1, input int v1,
                       input bit r2, input int v2);
    alloc_valid    = 1'b1;
    alloc_func     = FW'(f);
    alloc_rob      = TW'(rob);
    alloc_src1_rdy = r1;
    alloc_src1     = DW'(v1);
    alloc_src2_rdy = r2;
    alloc_src2     = DW'(v2);
  endtask

  task automatic cdb(input bit v, input int tag, input int data);
    cdb_valid = v;
    cdb_tag   = TW'(tag);
    cdb_data  = DW'(data);
  endtask

  initial begin
    iss_ready = 1'b1;
    repeat (2) @(posedge clk1);
    #1 rst_n = 1'b1;
    #1;
    chk("reset_count", count, 0);
    chk("reset_alloc_ready", alloc_ready, 1);
    chk("reset_iss_valid", iss_valid, 0);

    // both sources ready: issues one cycle after allocation
    alloc(0, 2, 1, 5, 1, 7);
    cyc();
    alloc_valid = 1'b0;
    chk("t1_valid", iss_valid, 1);
    chk("t1_op1", iss_op1, 5);
    chk("t1_op2", iss_op2, 7);
    chk("t1_rob", iss_rob, 2);
    chk("t1_count1", count, 1);
    cyc();
    chk("t1_count0", count, 0);

    // src1 waits for CDB tag 3
    alloc(1, 1, 0, 3, 1, 'h11);
    cyc();
    alloc_valid = 1'b0;
    chk("t2_wait0", iss_valid, 0);
    cyc();
    cdb(1, 3, 'h00AA);
    chk("t2_wait1", iss_valid, 0);
    cyc();
    cdb(0, 0, 0);
    chk("t2_valid", iss_valid, 1);
    chk("t2_op1", iss_op1, 'h00AA);
    chk("t2_op2", iss_op2, 'h11);
    cyc();
    chk("t2_count", count, 0);

    // fill, wake entry 2, refill into entry 2
    for (int k = 0; k < E; k++) begin
      alloc(k + 1, k, 0, 4 + k, 1, k);
      cyc();
    end
    alloc_valid = 1'b0;
    chk("t3_full_ready", alloc_ready, 0);
    chk("t3_full_count", count, 4);
    cdb(1, 6, 'h66);
    cyc();
    cdb(0, 0, 0);
    chk("t3_sel_rob", iss_rob, 2);
    chk("t3_sel_op1", iss_op1, 'h66);
    chk("t3_still_full", alloc_ready, 0);
    cyc();
    chk("t3_ready_back", alloc_ready, 1);
    chk("t3_count3", count, 3);
    alloc(7, 7, 1, 1, 1, 2);
    cyc();
    alloc_valid = 1'b0;
    chk("t3_refill_rob", iss_rob, 7);
    chk("t3_refill_count", count, 4);
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("t3_flush_count", count, 0);

    // held selection is not preempted by a lower entry waking
    iss_ready = 1'b0;
    alloc(0, 0, 0, 5, 1, 'h01);
    cyc();
    alloc(1, 1, 1, 'h10, 1, 'h11);
    cyc();
    alloc(2, 2, 0, 6, 1, 'h21);
    cyc();
    alloc(3, 3, 1, 'h30, 1, 'h31);
    cyc();
    alloc_valid = 1'b0;
    repeat (3) begin
      chk("t4_hold_rob", iss_rob, 1);
      chk("t4_hold_op1", iss_op1, 'h10);
      cyc();
    end
    cdb(1, 5, 'h55);
    cyc();
    cdb(0, 0, 0);
    chk("t4_nopreempt", iss_rob, 1);
    cyc();
    chk("t4_nopreempt2", iss_rob, 1);
    iss_ready = 1'b1;
    cyc();
    chk("t4_next_rob", iss_rob, 0);
    chk("t4_next_op1", iss_op1, 'h55);
    cyc();
    chk("t4_last_rob", iss_rob, 3);
    cyc();
    chk("t4_drained", iss_valid, 0);
    chk("t4_count", count, 1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;

    // allocation racing a matching CDB broadcast
    alloc(9, 3, 1, 1, 0, 4);
    cdb(1, 4, 9);
    #1;
`ifdef RS_CDB_BYPASS_EN
    chk("t5_alloc_ready", alloc_ready, 1);
    cyc();
    cdb(0, 0, 0);
    alloc_valid = 1'b0;
    chk("t5_byp_valid", iss_valid, 1);
    chk("t5_byp_op2", iss_op2, 9);
    cyc();
`else
    chk("t5_alloc_ready", alloc_ready, 0);
    cyc();
    cdb(0, 0, 0);
    chk("t5_stall_count", count, 0);
    alloc(9, 3, 1, 1, 1, 9);
    cyc();
    alloc_valid = 1'b0;
    chk("t5_retry_valid", iss_valid, 1);
    chk("t5_retry_op2", iss_op2, 9);
    cyc();
`endif
    chk("t5_count", count, 0);

    // flush with busy entries, an alloc and a matching CDB in the same cycle
    iss_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      alloc(k, k, 0, k + 1, 1, 0);
      cyc();
    end
    flush = 1'b1;
    alloc(4, 4, 1, 2, 1, 3);
    cdb(1, 1, 'h77);
    #1;
    chk("t6_flush_alloc_ready", alloc_ready, 0);
    cyc();
    flush = 1'b0;
    alloc_valid = 1'b0;
    cdb(0, 0, 0);
    chk("t6_count", count, 0);
    chk("t6_iss_valid", iss_valid, 0);

    // reset while a selection is stalled
    alloc(6, 5, 1, 'hA, 1, 'hB);
    cyc();
    alloc_valid = 1'b0;
    chk("t6_stall_valid", iss_valid, 1);
    cyc();
    chk("t6_stall_rob", iss_rob, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", iss_valid, 0);
    chk("t6_rst_count", count, 0);
    chk("t6_rst_alloc_ready", alloc_ready, 1);
    chk("t6_rst_rob", iss_rob, 0);
    chk("t6_rst_op1", iss_op1, 0);
    @(posedge clk1);
    #1 rst_n = 1'b1;
    iss_ready = 1'b1;
    cyc();
    chk("t6_post_count", count, 0);
    chk("t6_post_valid", iss_valid, 0);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
